othello_move_engine: RTL and testbench
======================================

# othello_move_engine

Validates and executes one Othello move on the 64-cell board memory. When the main game controller raises `new_move`, the engine checks the target cell and scans all 8 directions from it. It writes the flipped discs and the placed disc back to board memory, then pulses `ack` for a legal move or `reject` for an illegal one. It sits between the main game controller and the board RAM, and is the only writer of the board after initialization.

## Interface
- No parameters; the board is fixed at 8x8 with a 2-bit cell code.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `new_move` in 1: start request; level signal from the main controller.
- `player` in 1: 0 = black moves, 1 = white moves; sampled at start.
- `move_x`, `move_y` in 3 each: target column and row; sampled at start.
- `rd_addr` out 6: board read address, `{y,x}`.
- `rd_data` in 2: board read data, valid the cycle after `rd_addr` is presented (synchronous RAM).
- `wr_en` out 1: board write strobe.
- `wr_addr` out 6: board write address.
- `wr_data` out 2: board write data.
- `busy` out 1: high from start until the ack/reject cycle, inclusive.
- `ack` out 1: one-cycle pulse; the move was legal and has been fully written.
- `reject` out 1: one-cycle pulse; the move was illegal and nothing was written.

## Operation
- Cell codes: 00 empty, 01 black, 10 white, 11 unused. Own colour = `player ? 10 : 01`; the opponent is the other colour.
- States: IDLE, CHK_RD, CHK_EV, DIR_INIT, SCAN_RD, SCAN_EV, FLIP, NEXT_DIR, PLACE, DONE, REJECT, HOLD.
- IDLE: when `new_move`=1, latch `player`, `move_x`, `move_y`, go to CHK_RD.
- CHK_RD / CHK_EV: read the target cell. If it is non-empty, go to REJECT; otherwise set d=0 and go to DIR_INIT.
- Direction order d=0..7 as (dy,dx): N(-1,0), NE(-1,+1), E(0,+1), SE(+1,+1), S(+1,0), SW(+1,-1), W(0,-1), NW(-1,-1).
- DIR_INIT: set run=0 and position = target + delta.
- Off-board step (4-bit signed coordinate outside 0..7): go to NEXT_DIR.
- SCAN_RD / SCAN_EV: read the cell at the current position.
  - Opponent disc: run++, step the position, go back to SCAN_RD (off-board step goes to NEXT_DIR).
  - Own disc with run≥1: go to FLIP.
  - Own disc with run=0, or empty cell: go to NEXT_DIR.
- FLIP: write own colour to target+k·delta for k=1..run, one write per cycle; add run to total, then go to NEXT_DIR.
- NEXT_DIR: if d<7, d++ and go to DIR_INIT. If d=7, go to PLACE when total>0, else REJECT.
- PLACE: write own colour to the target cell, then go to DONE.
- DONE pulses `ack`; REJECT pulses `reject`. Both go to HOLD.
- HOLD: wait for `new_move`=0, then go to IDLE. A new attempt therefore needs `new_move` low for at least 1 cycle.
- Flips in one direction never touch cells scanned in later directions, so immediate write-back is safe.
- `new_move` falling mid-operation is ignored; the move completes and ack/reject still pulses.
- `move_*` and `player` changes after start are ignored.

## Timing
- Reset values: state IDLE; `busy`, `ack`, `reject`, `wr_en` = 0; `rd_addr`, `wr_addr`, `wr_data`, total = 0.
- If `new_move` is sampled high in IDLE at cycle t:
  - CHK_RD occupies t+1.
  - An occupied target gives `reject` at t+3.
- Each scanned cell costs 2 cycles; each flip costs 1 cycle; each direction adds 1 cycle of overhead (DIR_INIT) plus 1 (NEXT_DIR).
- `wr_en` is high only in FLIP and PLACE. `ack` is asserted the cycle after the PLACE write.
- Worst case is under 100 cycles.
- Asynchronous reset mid-move forces IDLE and `wr_en`=0 immediately. Partial flips already written are not undone.

## Configuration
- `OTHELLO_FLIP_COUNT_EN` defined: adds output `flip_count` (5 bits) holding the total number of flipped discs. It is valid from the `ack` cycle until the next start, and reads 0 after `reject` or reset.
- Not defined: the port and the extra register are absent; behaviour is otherwise identical.

## Structure
- `othello_pkg` holds:
  - cell code constants `CELL_EMPTY`, `CELL_BLACK`, `CELL_WHITE`;
  - the 8-entry direction delta table;
  - the engine state encoding, shared with the main controller's package.
- Sub-module `othello_coord_step` (combinational): inputs {y,x} and d, outputs next {y,x} and `off_board`. It is used for both scanning and flip addressing.

## Test plan
- Standard opening (27=W, 28=B, 35=B, 36=W); black plays y=2,x=3 → single write 27←01, then 19←01; `ack`; `flip_count`=1.
- Black plays the occupied cell 27 → `reject` at t+3; `wr_en` never asserted.
- Black plays 0,0 on the opening board → 8 directions end off-board or on empty cells; `reject`; no writes.
- Row 0 = B W W W W W W W (x=0..7); black plays y=1 at a capture-free point; separately, a white run to the edge with no closing own disc → no flip in that direction.
- Target with captures in N and E (run 2 and run 1) → writes in N then E order, then place; `flip_count`=3.
- Assert `reset` during FLIP → `wr_en` drops the same cycle; after release the engine is IDLE and accepts a new `new_move`.

Source files
------------

// File: rtl/othello_pkg.sv
// Shared definitions for the Othello move engine: cell codes, direction table
// and the engine state encoding used by the main controller as well.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  typedef struct packed {
    logic signed [1:0] dy;
    logic signed [1:0] dx;
  } delta_t;

  // Index d = 0..7 : N, NE, E, SE, S, SW, W, NW  (2'b11 encodes -1)
  localparam delta_t DIR_DELTA [8] = '{
    '{dy: 2'b11, dx: 2'b00},
    '{dy: 2'b11, dx: 2'b01},
    '{dy: 2'b00, dx: 2'b01},
    '{dy: 2'b01, dx: 2'b01},
    '{dy: 2'b01, dx: 2'b00},
    '{dy: 2'b01, dx: 2'b11},
    '{dy: 2'b00, dx: 2'b11},
    '{dy: 2'b11, dx: 2'b11}
  };

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHK_RD,
    ST_CHK_EV,
    ST_DIR_INIT,
    ST_SCAN_RD,
    ST_SCAN_EV,
    ST_FLIP,
    ST_NEXT_DIR,
    ST_PLACE,
    ST_DONE,
    ST_REJECT,
    ST_HOLD
  } engine_state_t;

  function automatic logic [1:0] own_cell(input logic player);
    return player ? CELL_WHITE : CELL_BLACK;
  endfunction

  function automatic logic [1:0] opp_cell(input logic player);
    return player ? CELL_BLACK : CELL_WHITE;
  endfunction

endpackage

// File: rtl/othello_move_engine_if.sv
// Controller + board RAM bus of the move engine. flip_count exists only when
// OTHELLO_FLIP_COUNT_EN is defined.
interface othello_move_engine_if;
  logic       new_move;
  logic       player;
  logic [2:0] move_x;
  logic [2:0] move_y;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [1:0] wr_data;
  logic       busy;
  logic       ack;
  logic       reject;
`ifdef OTHELLO_FLIP_COUNT_EN
  logic [4:0] flip_count;

  modport master (
    output new_move, player, move_x, move_y, rd_data,
    input  rd_addr, wr_en, wr_addr, wr_data, busy, ack, reject, flip_count
  );
  modport slave (
    input  new_move, player, move_x, move_y, rd_data,
    output rd_addr, wr_en, wr_addr, wr_data, busy, ack, reject, flip_count
  );
`else
  modport master (
    output new_move, player, move_x, move_y, rd_data,
    input  rd_addr, wr_en, wr_addr, wr_data, busy, ack, reject
  );
  modport slave (
    input  new_move, player, move_x, move_y, rd_data,
    output rd_addr, wr_en, wr_addr, wr_data, busy, ack, reject
  );
`endif
endinterface

// File: rtl/othello_coord_step.sv
// One step from board position {y,x} along direction d; flags leaving the board.
module othello_coord_step
  import othello_pkg::*;
(
  input  logic [5:0] pos_i,
  input  logic [2:0] dir_i,
  output logic [5:0] pos_o,
  output logic       off_board_o
);

  delta_t            delta;
  logic signed [3:0] ny;
  logic signed [3:0] nx;

  // 4-bit signed coordinates: -1 and 8 both have bit 3 set.
  always_comb begin
    delta       = DIR_DELTA[dir_i];
    ny          = $signed({1'b0, pos_i[5:3]}) + $signed({{2{delta.dy[1]}}, delta.dy});
    nx          = $signed({1'b0, pos_i[2:0]}) + $signed({{2{delta.dx[1]}}, delta.dx});
    off_board_o = ny[3] | nx[3];
    pos_o       = {ny[2:0], nx[2:0]};
  end

endmodule

// File: rtl/othello_move_engine.sv
// Validates and executes one Othello move against the synchronous board RAM.
// Optional flip_count output enabled by OTHELLO_FLIP_COUNT_EN.
module othello_move_engine
  import othello_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  othello_move_engine_if.slave  bus
);

  engine_state_t state_q, state_d;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic       reject_q, reject_d;
  logic       wr_en_q, wr_en_d;
  logic [5:0] rd_addr_q, rd_addr_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic [1:0] wr_data_q, wr_data_d;
  logic [4:0] total_q, total_d;

  logic       player_q, player_d;
  logic [5:0] tgt_q, tgt_d;
  logic [5:0] pos_q, pos_d;
  logic [5:0] first_q, first_d;
  logic [2:0] dir_q, dir_d;
  logic [2:0] run_q, run_d;

  logic [5:0] step_in;
  logic [5:0] step_pos;
  logic       step_off;
  logic [1:0] own_c;
  logic [1:0] opp_c;

  assign own_c = own_cell(player_q);
  assign opp_c = opp_cell(player_q);

  // The single stepper serves the first cell of a direction, the scan walk
  // and the flip walk (which follows the write address).
  always_comb begin
    step_in = pos_q;
    if (state_q == ST_DIR_INIT) step_in = tgt_q;
    else if (state_q == ST_FLIP) step_in = wr_addr_q;
  end

  othello_coord_step u_step (
    .pos_i       (step_in),
    .dir_i       (dir_q),
    .pos_o       (step_pos),
    .off_board_o (step_off)
  );

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    reject_d  = 1'b0;
    wr_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    total_d   = total_q;
    player_d  = player_q;
    tgt_d     = tgt_q;
    pos_d     = pos_q;
    first_d   = first_q;
    dir_d     = dir_q;
    run_d     = run_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.new_move) begin
          player_d  = bus.player;
          tgt_d     = {bus.move_y, bus.move_x};
          rd_addr_d = {bus.move_y, bus.move_x};
          total_d   = '0;
          state_d   = ST_CHK_RD;
        end
      end
      ST_CHK_RD: state_d = ST_CHK_EV;
      ST_CHK_EV: begin
        if (bus.rd_data != CELL_EMPTY) begin
          reject_d = 1'b1;
          state_d  = ST_REJECT;
        end else begin
          dir_d   = '0;
          state_d = ST_DIR_INIT;
        end
      end
      ST_DIR_INIT: begin
        run_d = '0;
        if (step_off) begin
          state_d = ST_NEXT_DIR;
        end else begin
          pos_d     = step_pos;
          first_d   = step_pos;
          rd_addr_d = step_pos;
          state_d   = ST_SCAN_RD;
        end
      end
      ST_SCAN_RD: state_d = ST_SCAN_EV;
      ST_SCAN_EV: begin
        if (bus.rd_data == opp_c) begin
          run_d = run_q + 3'd1;
          if (step_off) begin
            state_d = ST_NEXT_DIR;
          end else begin
            pos_d     = step_pos;
            rd_addr_d = step_pos;
            state_d   = ST_SCAN_RD;
          end
        end else if (bus.rd_data == own_c && run_q != 3'd0) begin
          // run is credited up front; FLIP then counts it down to 1.
          total_d   = total_q + {2'b00, run_q};
          wr_en_d   = 1'b1;
          wr_addr_d = first_q;
          wr_data_d = own_c;
          state_d   = ST_FLIP;
        end else begin
          state_d = ST_NEXT_DIR;
        end
      end
      ST_FLIP: begin
        if (run_q > 3'd1) begin
          run_d     = run_q - 3'd1;
          wr_en_d   = 1'b1;
          wr_addr_d = step_pos;
        end else begin
          state_d = ST_NEXT_DIR;
        end
      end
      ST_NEXT_DIR: begin
        if (dir_q != 3'd7) begin
          dir_d   = dir_q + 3'd1;
          state_d = ST_DIR_INIT;
        end else if (total_q != 5'd0) begin
          wr_en_d   = 1'b1;
          wr_addr_d = tgt_q;
          wr_data_d = own_c;
          state_d   = ST_PLACE;
        end else begin
          reject_d = 1'b1;
          state_d  = ST_REJECT;
        end
      end
      ST_PLACE: begin
        ack_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE, ST_REJECT: state_d = ST_HOLD;
      ST_HOLD: if (!bus.new_move) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = !(state_d inside {ST_IDLE, ST_HOLD});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      reject_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      reject_q  <= reject_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      total_q   <= total_d;
    end
  end

  // Move-context registers are always loaded before use, so no reset.
  always_ff @(posedge clock) begin
    player_q <= player_d;
    tgt_q    <= tgt_d;
    pos_q    <= pos_d;
    first_q  <= first_d;
    dir_q    <= dir_d;
    run_q    <= run_d;
  end

  assign bus.busy    = busy_q;
  assign bus.ack     = ack_q;
  assign bus.reject  = reject_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

`ifdef OTHELLO_FLIP_COUNT_EN
  logic [4:0] flip_count_q, flip_count_d;

  // DONE is entered only from PLACE, when total is final.
  always_comb begin
    flip_count_d = flip_count_q;
    if (state_d == ST_DONE && state_q == ST_PLACE) flip_count_d = total_q;
    else if (state_d == ST_REJECT || state_d == ST_CHK_RD) flip_count_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) flip_count_q <= '0;
    else       flip_count_q <= flip_count_d;
  end

  assign bus.flip_count = flip_count_q;
`endif

endmodule

// File: tb/tb_othello_move_engine.sv
// Directed bench for othello_move_engine with a board RAM model and a queue of
// expected writes.
module tb_othello_move_engine;
  import othello_pkg::*;

  typedef struct packed {
    logic [5:0] addr;
    logic [1:0] data;
  } wr_t;

  logic clock;
  logic reset;
  othello_move_engine_if bus();

  othello_move_engine dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [1:0] board [64];
  logic [1:0] img   [64];
  logic       ld;
  wr_t        exp_wr [$];
  int         checks;
  int         errors;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ld) begin
      for (int i = 0; i < 64; i++) board[i] <= img[i];
    end else if (bus.wr_en) begin
      board[bus.wr_addr] <= bus.wr_data;
    end
    bus.rd_data <= board[bus.rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = CELL_EMPTY;
  endtask

  task automatic load_board();
    ld = 1'b1;
    @(negedge clock);
    ld = 1'b0;
  endtask

  task automatic opening_img();
    clear_img();
    img[27] = CELL_WHITE;
    img[28] = CELL_BLACK;
    img[35] = CELL_BLACK;
    img[36] = CELL_WHITE;
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [1:0] d);
    exp_wr.push_back('{addr: a, data: d});
  endtask

  task automatic check_write(input string tag);
    wr_t e;
    if (exp_wr.size() == 0) begin
      chk({tag, "_unexpected_write"}, {26'd0, bus.wr_addr}, 32'hFFFF_FFFF);
    end else begin
      e = exp_wr.pop_front();
      chk({tag, "_wr_addr"}, {26'd0, bus.wr_addr}, {26'd0, e.addr});
      chk({tag, "_wr_data"}, {30'd0, bus.wr_data}, {30'd0, e.data});
    end
  endtask

  // Drives one move and follows it to ack/reject; exp_lat > 0 also pins
  // the cycle (counted from the first cycle after sampling) of the pulse.
  task automatic do_move(input string tag, input logic p, input logic [2:0] y,
                         input logic [2:0] x, input logic exp_ack,
                         input int exp_fc, input int exp_lat);
    int n;
    bit done;
    bus.player   = p;
    bus.move_y   = y;
    bus.move_x   = x;
    bus.new_move = 1'b1;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
      if (n == 1) chk({tag, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
      if (n == 1) begin
        bus.player = ~p;
        bus.move_x = ~x;
      end
      if (bus.wr_en) check_write(tag);
      if (bus.ack || bus.reject) begin
        done = 1'b1;
        chk({tag, "_ack"}, {31'd0, bus.ack}, {31'd0, exp_ack});
        chk({tag, "_reject"}, {31'd0, bus.reject}, {31'd0, !exp_ack});
        chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd1);
        if (exp_lat > 0) chk({tag, "_latency"}, n, exp_lat);
      end
    end
    if (!done) chk({tag, "_timeout"}, n, 32'd0);
    chk({tag, "_writes_left"}, exp_wr.size(), 32'd0);
    exp_wr.delete();
`ifdef OTHELLO_FLIP_COUNT_EN
    chk({tag, "_flip_count"}, {27'd0, bus.flip_count}, exp_fc);
`endif
    @(negedge clock);
    chk({tag, "_pulse_done"}, {30'd0, bus.ack, bus.reject}, 32'd0);
    chk({tag, "_hold_busy"}, {31'd0, bus.busy}, 32'd0);
    @(negedge clock);
    chk({tag, "_hold_no_restart"}, {30'd0, bus.busy, bus.wr_en}, 32'd0);
`ifdef OTHELLO_FLIP_COUNT_EN
    chk({tag, "_flip_count_hold"}, {27'd0, bus.flip_count}, exp_fc);
`endif
    bus.new_move = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    int seen;
    checks       = 0;
    errors       = 0;
    ld           = 1'b0;
    reset        = 1'b1;
    bus.new_move = 1'b0;
    bus.player   = 1'b0;
    bus.move_x   = '0;
    bus.move_y   = '0;
    clear_img();
    @(negedge clock);
    load_board();
    chk("rst_busy",    {31'd0, bus.busy},    32'd0);
    chk("rst_ack",     {31'd0, bus.ack},     32'd0);
    chk("rst_reject",  {31'd0, bus.reject},  32'd0);
    chk("rst_wr_en",   {31'd0, bus.wr_en},   32'd0);
    chk("rst_rd_addr", {26'd0, bus.rd_addr}, 32'd0);
    chk("rst_wr_addr", {26'd0, bus.wr_addr}, 32'd0);
    chk("rst_wr_data", {30'd0, bus.wr_data}, 32'd0);
`ifdef OTHELLO_FLIP_COUNT_EN
    chk("rst_flip_count", {27'd0, bus.flip_count}, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clock);

    // Black (2,3) on the opening: flips 27 via S, then places 19.
    opening_img();
    load_board();
    push_wr(6'd27, CELL_BLACK);
    push_wr(6'd19, CELL_BLACK);
    do_move("open_legal", 1'b0, 3'd2, 3'd3, 1'b1, 1, 39);
    chk("open_board19", {30'd0, board[19]}, {30'd0, CELL_BLACK});
    chk("open_board27", {30'd0, board[27]}, {30'd0, CELL_BLACK});

    opening_img();
    load_board();
    do_move("occupied", 1'b0, 3'd3, 3'd3, 1'b0, 0, 3);

    do_move("corner", 1'b0, 3'd0, 3'd0, 1'b0, 0, 0);

    // Row 0 = B W W W W W W W; (1,7) only sees white runs ending off-board.
    clear_img();
    img[0] = CELL_BLACK;
    for (int i = 1; i < 8; i++) img[i] = CELL_WHITE;
    load_board();
    do_move("edge_run", 1'b0, 3'd1, 3'd7, 1'b0, 0, 0);
    chk("edge_board15", {30'd0, board[15]}, {30'd0, CELL_EMPTY});

    // N run 2 (26,18 closed by 10) and E run 1 (35 closed by 36).
    clear_img();
    img[10] = CELL_BLACK;
    img[18] = CELL_WHITE;
    img[26] = CELL_WHITE;
    img[35] = CELL_WHITE;
    img[36] = CELL_BLACK;
    load_board();
    push_wr(6'd26, CELL_BLACK);
    push_wr(6'd18, CELL_BLACK);
    push_wr(6'd35, CELL_BLACK);
    push_wr(6'd34, CELL_BLACK);
    do_move("n_and_e", 1'b0, 3'd4, 3'd2, 1'b1, 3, 0);

    // White (7,0): black row to the east edge is not closed; N flips 48.
    clear_img();
    for (int i = 57; i < 64; i++) img[i] = CELL_BLACK;
    img[48] = CELL_BLACK;
    img[40] = CELL_WHITE;
    load_board();
    push_wr(6'd48, CELL_WHITE);
    push_wr(6'd56, CELL_WHITE);
    do_move("white_edge", 1'b1, 3'd7, 3'd0, 1'b1, 1, 0);

    // Reset during the second flip write of the N run.
    clear_img();
    img[10] = CELL_BLACK;
    img[18] = CELL_WHITE;
    img[26] = CELL_WHITE;
    img[35] = CELL_WHITE;
    img[36] = CELL_BLACK;
    load_board();
    push_wr(6'd26, CELL_BLACK);
    push_wr(6'd18, CELL_BLACK);
    bus.player   = 1'b0;
    bus.move_y   = 3'd4;
    bus.move_x   = 3'd2;
    bus.new_move = 1'b1;
    seen = 0;
    for (int n = 0; n < 200 && seen < 2; n++) begin
      @(negedge clock);
      if (bus.wr_en) begin
        check_write("rst_flip");
        seen++;
      end
    end
    chk("rst_flip_reached", seen, 32'd2);
    #2;
    reset        = 1'b1;
    bus.new_move = 1'b0;
    #1;
    chk("rst_flip_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("rst_flip_busy",  {31'd0, bus.busy},  32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_flip_idle", {30'd0, bus.busy, bus.wr_en}, 32'd0);
    chk("rst_flip_kept26", {30'd0, board[26]}, {30'd0, CELL_BLACK});
    chk("rst_flip_kept18", {30'd0, board[18]}, {30'd0, CELL_WHITE});
    chk("rst_flip_noplace", {30'd0, board[34]}, {30'd0, CELL_EMPTY});
    exp_wr.delete();

    opening_img();
    load_board();
    push_wr(6'd27, CELL_BLACK);
    push_wr(6'd19, CELL_BLACK);
    do_move("after_reset", 1'b0, 3'd2, 3'd3, 1'b1, 1, 39);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
